// File: rtl/pump_array_ctrl_if.sv
// Command link between the Pico and the pump array controller: a 4-phase REQ/ACK
// handshake carrying {channel, target_duty}, plus a reject pulse.
interface pump_array_ctrl_if #(
    parameter int N_CH     = 2,
    parameter int PWM_BITS = 8
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CMD_W = CH_W + PWM_BITS;

    logic [CMD_W-1:0] cmd_data;
    logic             cmd_req;
    logic             cmd_ack;
    logic             cmd_err;

    modport master (output cmd_data, output cmd_req, input cmd_ack, input cmd_err);
    modport slave  (input cmd_data, input cmd_req, output cmd_ack, output cmd_err);
endinterface

// File: rtl/pump_array_ctrl.sv
// N-channel pump controller: REQ/ACK command intake, per-channel dry-sensor debounce,
// soft-start duty ramp, dry-run fault latch and glitch-free PWM outputs.
module pump_array_ctrl #(
    parameter int N_CH        = 2,
    parameter int PWM_BITS    = 8,
    parameter int DEB_CYCLES  = 500_000,
    parameter int RAMP_CYCLES = 25_000
) (
    input  logic                 clk,
    input  logic                 reset,
    pump_array_ctrl_if.slave     cmd,
    input  logic [N_CH-1:0]      sensor_dry,
    output logic [N_CH-1:0]      pwm_out,
    output logic [N_CH-1:0]      fault
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CMD_W  = CH_W + PWM_BITS;
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

    localparam logic [1:0] HS_IDLE     = 2'd0;
    localparam logic [1:0] HS_ACK      = 2'd1;
    localparam logic [1:0] HS_WAIT_LOW = 2'd2;

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RAMP  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic                               req_s1, req_s2;
    logic [N_CH-1:0]                    dry_s1, dry_s2;
    logic [1:0]                         hs_state;
    logic                               cmd_valid;
    logic [CH_W-1:0]                    cmd_ch;
    logic [PWM_BITS-1:0]                cmd_duty;

    logic [N_CH-1:0]                    deb, deb_next, trip, cmd_hit;
    logic [N_CH-1:0][DEB_W-1:0]         deb_cnt;
    logic [RAMP_W-1:0]                  pre_cnt;
    logic                               tick;
    logic [PWM_BITS-1:0]                pwm_cnt;
    logic                               pwm_wrap;

    logic [N_CH-1:0][1:0]               ch_state;
    logic [N_CH-1:0][PWM_BITS-1:0]      cur, target, applied, tgt_eff, cur_nxt;

    assign cmd_ch    = cmd.cmd_data[CMD_W-1:PWM_BITS];
    assign cmd_duty  = cmd.cmd_data[PWM_BITS-1:0];
    assign cmd_valid = (hs_state == HS_IDLE) && req_s2;
    assign tick      = (pre_cnt == RAMP_W'(RAMP_CYCLES - 1));
    assign pwm_wrap  = &pwm_cnt;

    // deb_next is the debounced value after this edge, so a trip lands on the flip edge.
    always_comb begin
        deb_next = deb;
        trip     = '0;
        cmd_hit  = '0;
        tgt_eff  = target;
        cur_nxt  = cur;
        fault    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (dry_s2[i] != deb[i] && deb_cnt[i] == DEB_W'(DEB_CYCLES - 1))
                deb_next[i] = ~deb[i];
            trip[i]    = deb_next[i] && (ch_state[i] != ST_FAULT) &&
                         (target[i] != '0 || cur[i] != '0);
            cmd_hit[i] = cmd_valid && (cmd_ch == CH_W'(i)) &&
                         (ch_state[i] != ST_FAULT) && !trip[i];
            if (cmd_hit[i])
                tgt_eff[i] = cmd_duty;
            if (tick && cur[i] < tgt_eff[i])
                cur_nxt[i] = cur[i] + 1'b1;
            else if (tick && cur[i] > tgt_eff[i])
                cur_nxt[i] = cur[i] - 1'b1;
            fault[i] = (ch_state[i] == ST_FAULT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_s1      <= 1'b0;
            req_s2      <= 1'b0;
            dry_s1      <= '1;
            dry_s2      <= '1;
            hs_state    <= HS_IDLE;
            cmd.cmd_ack <= 1'b0;
            cmd.cmd_err <= 1'b0;
        end else begin
            req_s1      <= cmd.cmd_req;
            req_s2      <= req_s1;
            dry_s1      <= sensor_dry;
            dry_s2      <= dry_s1;
            cmd.cmd_err <= 1'b0;
            case (hs_state)
                HS_IDLE: begin
                    if (req_s2) begin
                        hs_state    <= HS_ACK;
                        cmd.cmd_ack <= 1'b1;
                        cmd.cmd_err <= ~(|cmd_hit);
                    end
                end
                HS_ACK:
                    hs_state <= HS_WAIT_LOW;
                HS_WAIT_LOW: begin
                    if (!req_s2) begin
                        hs_state    <= HS_IDLE;
                        cmd.cmd_ack <= 1'b0;
                    end
                end
                default:
                    hs_state <= HS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb     <= '1;
            deb_cnt <= '0;
        end else begin
            deb <= deb_next;
            for (int i = 0; i < N_CH; i++) begin
                if (dry_s2[i] == deb[i] || deb_next[i] != deb[i])
                    deb_cnt[i] <= '0;
                else
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // A trip zeroes applied at once; otherwise applied only follows cur at PWM wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_state <= '0;
            cur      <= '0;
            target   <= '0;
            applied  <= '0;
            pwm_out  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                pwm_out[i] <= (pwm_cnt < applied[i]);
                if (trip[i]) begin
                    ch_state[i] <= ST_FAULT;
                    cur[i]      <= '0;
                    target[i]   <= '0;
                    applied[i]  <= '0;
                end else if (ch_state[i] == ST_FAULT) begin
                    if (!deb_next[i])
                        ch_state[i] <= ST_STOP;
                end else begin
                    target[i] <= tgt_eff[i];
                    cur[i]    <= cur_nxt[i];
                    if (pwm_wrap)
                        applied[i] <= cur[i];
                    if (cur_nxt[i] != tgt_eff[i])
                        ch_state[i] <= ST_RAMP;
                    else if (tgt_eff[i] == '0)
                        ch_state[i] <= ST_STOP;
                    else
                        ch_state[i] <= ST_RUN;
                end
            end
        end
    end
endmodule
